// File: rtl/fpdiv_sched_pkg.sv
// Shared types and defaults for the two-requester FP16 divider scheduler.
package fpdiv_sched_pkg;

    localparam int unsigned DEF_LATENCY = 6;
    localparam int unsigned DEF_DATA_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic req_id_t onehot_to_id(input logic [1:0] oh);
        return oh[1] ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie, the requester not granted last wins.
module rr_arb2
    import fpdiv_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    input  logic       advance,
    output logic [1:0] grant
);

    req_id_t last_q;

    always_comb begin
        grant = '0;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == REQ1) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // Reset leaves "requester 1 granted last" so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= REQ1;
        end else if (advance && (|grant)) begin
            last_q <= onehot_to_id(grant);
        end
    end

endmodule

// File: rtl/fpdiv_sched.sv
// Schedules two requesters onto one shared multi-cycle FP16 divider and holds
// each requester's quotient until it is consumed.
module fpdiv_sched
    import fpdiv_sched_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_q,
    input  logic              req0_rready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_q,
    input  logic              req1_rready,
    output logic              div_en,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic [DATA_W-1:0] div_q,
    output logic              busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    req_id_t             owner_q;
    logic [DATA_W-1:0]   div_a_q;
    logic [DATA_W-1:0]   div_b_q;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   q0_q;
    logic [DATA_W-1:0]   q1_q;

    logic [1:0]          valid_v;
    logic [1:0]          rready_v;
    logic [1:0]          eligible;
    logic [1:0]          grant;
    logic                advance;
    logic                last_step;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;

    assign valid_v  = {req1_valid, req0_valid};
    assign rready_v = {req1_rready, req0_rready};

    // Grants only in IDLE and never while reset is held, so ready cannot pulse during reset.
    assign eligible = (state_q == ST_IDLE && reset) ? (valid_v & ~rvalid_q) : 2'b00;
    assign advance  = |grant;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .advance  (advance),
        .grant    (grant)
    );

    assign sel_a     = grant[1] ? req1_a : req0_a;
    assign sel_b     = grant[1] ? req1_b : req0_b;
    assign last_step = (state_q == ST_BUSY) && (cnt_q == CNT_W'(LATENCY - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= REQ0;
            div_a_q  <= '0;
            div_b_q  <= '0;
            rvalid_q <= '0;
            q0_q     <= '0;
            q1_q     <= '0;
        end else begin
            // Consumption first; a completing operation below can only set the
            // owner's flag, which is known clear because it was eligible at grant.
            rvalid_q <= rvalid_q & ~rready_v;
            case (state_q)
                ST_IDLE: begin
                    if (advance) begin
                        div_a_q <= sel_a;
                        div_b_q <= sel_b;
                        owner_q <= onehot_to_id(grant);
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (last_step) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        case (owner_q)
                            REQ0: begin
                                rvalid_q[0] <= 1'b1;
                                q0_q        <= div_q;
                            end
                            REQ1: begin
                                rvalid_q[1] <= 1'b1;
                                q1_q        <= div_q;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign req0_rvalid = rvalid_q[0];
    assign req1_rvalid = rvalid_q[1];
    assign req0_q      = q0_q;
    assign req1_q      = q1_q;
    assign div_en      = (state_q == ST_BUSY);
    assign busy        = (state_q == ST_BUSY);
    assign div_a       = div_a_q;
    assign div_b       = div_b_q;

endmodule

// File: doc/fpdiv_sched.md
FPDIV_SCHED -- requirements
Module: fpdiv_sched

Interface
REQ-001 Parameter LATENCY, default 6, SHALL be the number of enabled cycles the shared FP16 divider needs before its quotient is valid.
REQ-002 Parameter DATA_W, default 16, SHALL be the operand and quotient width (FP16).
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  block clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N = 0, 1) presents an operation.
REQ-007 reqN_a, reqN_b  input  DATA_W  requester N dividend and divisor.
REQ-008 reqN_ready  output  1  one-cycle pulse: operands of requester N accepted.
REQ-009 reqN_rvalid  output  1  result for requester N held valid.
REQ-010 reqN_q  output  DATA_W  result for requester N.
REQ-011 reqN_rready  input  1  requester N consumes its result.
REQ-012 div_en  output  1  enable to the shared divider.
REQ-013 div_a, div_b  output  DATA_W  operands to the shared divider.
REQ-014 div_q  input  DATA_W  quotient from the shared divider.
REQ-015 busy  output  1  high while a division is in flight.

Function
REQ-016 The FSM SHALL have states IDLE and BUSY; one operation is in flight at a time.
REQ-017 In IDLE, requester N SHALL be eligible when reqN_valid=1 and reqN_rvalid=0.
REQ-018 With one eligible requester, it SHALL be granted; with both, the one not granted last SHALL win (round-robin); after reset, requester 0 wins the first tie.
REQ-019 On a grant, the block SHALL pulse reqN_ready for exactly that cycle, register reqN_a/reqN_b into div_a/div_b, record the owner, and enter BUSY next cycle.
REQ-020 Requesters SHALL hold valid and operands stable until ready; if valid drops before the grant, nothing SHALL be issued.
REQ-021 In BUSY, div_en=1, busy=1, and div_a/div_b SHALL stay stable; a counter SHALL run 0..LATENCY-1, one step per cycle.
REQ-022 On the clock edge ending the cycle with counter=LATENCY-1, the block SHALL capture div_q into the owner's reqN_q, set its reqN_rvalid, and return to IDLE; total latency is LATENCY+1 cycles from the ready pulse to rvalid.
REQ-023 reqN_rvalid and reqN_q SHALL hold until the cycle in which reqN_rready=1, then clear rvalid on the next edge; reqN_q holds its last value.
REQ-024 No new grant SHALL be made in the return-to-IDLE cycle; the earliest next grant is the first IDLE cycle.
REQ-025 A requester whose rvalid is set SHALL be skipped, and the other requester MAY be granted meanwhile.
REQ-026 An rready received while rvalid=0 SHALL be ignored.
REQ-027 div_en SHALL be 0 in IDLE, and div_a/div_b SHALL keep their last values.

Reset
REQ-028 Assertion of reset (low) SHALL immediately force IDLE, counter=0, div_en=0, busy=0, div_a=div_b=0, all reqN_ready=0, reqN_rvalid=0, reqN_q=0, and round-robin priority to requester 0.
REQ-029 A reset during BUSY SHALL abandon the operation with no result delivered; operation resumes on the first clk edge after deassertion.

Structure
REQ-030 Package fpdiv_sched_pkg SHALL hold the FSM state type, the default LATENCY/DATA_W constants and the requester-id type.
REQ-031 The 2-way round-robin selection SHALL be a sub-module named rr_arb2 (inputs: eligible[1:0], advance; output: grant[1:0]).

Verification
REQ-032 Single request: req0 a=4400 b=4000 -> req0_ready pulse, div_en high 6 cycles, req0_rvalid with req0_q=4000 7 cycles after ready.
REQ-033 Simultaneous: both valid after reset (req0 3C00/4000, req1 4500/4400) -> req0 is served first (q=3800), then req1 (q=3D00); no overlap of div_en windows.
REQ-034 Fairness: both valid continuously, results consumed immediately -> grants alternate 0,1,0,1.
REQ-035 Result backpressure: req0_rready held 0 with req0 re-requesting -> req0 not granted; req1 granted; req0 granted once its result is consumed.
REQ-036 Reset mid-BUSY at counter=3 -> all outputs at reset values at once; no rvalid after deassertion until a new grant.
REQ-037 Operand stability: change req0_a after ready -> div_a unchanged through BUSY.
